// File: rtl/neurex_pkg.sv
// Shared types and default sizing for the neurex output-memory path.
// Holds the drain controller state encoding and the signed data/accumulator word types.
package neurex_pkg;

  localparam int NX_SYS_COL    = 16;
  localparam int NX_DATA_WIDTH = 16;
  localparam int NX_ACC_WIDTH  = 32;
  localparam int NX_ACCUM_ROW  = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } ctrl_state_e;

  typedef logic signed [NX_DATA_WIDTH-1:0] data_t;
  typedef logic signed [NX_ACC_WIDTH-1:0]  acc_t;

endpackage

// File: rtl/acc_bank.sv
// One column bank: write pointer plus overwrite/accumulate write, combinational read port.
// Writes land on the clock edge; reads have zero latency; writes past num_row are refused (full).
module acc_bank #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int ACCUM_ROW  = 128,
  parameter int ADDR_WIDTH = $clog2(ACCUM_ROW)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         clr,
  input  logic                         wr_en,
  input  logic                         acc_en,
  input  logic [ADDR_WIDTH:0]          num_row,
  input  logic signed [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0]        rd_addr,
  output logic signed [ACC_WIDTH-1:0]  rd_data,
  output logic                         full,
  output logic                         last_slot
);

  localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);

  logic signed [ACC_WIDTH-1:0] mem [ACCUM_ROW];
  logic [ADDR_WIDTH:0]         wr_ptr;
  logic signed [ACC_WIDTH-1:0] wr_ext;
  logic                        wr_ok;

  assign full      = (wr_ptr == num_row);
  assign last_slot = ((wr_ptr + CNT_ONE) == num_row);
  assign wr_ok     = wr_en && !full;
  assign wr_ext    = {{(ACC_WIDTH-DATA_WIDTH){wr_data[DATA_WIDTH-1]}}, wr_data};
  assign rd_data   = mem[rd_addr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
    end else if (wr_ok) begin
      wr_ptr <= wr_ptr + CNT_ONE;
    end
  end

  // Contents deliberately survive reset so K-tiles can accumulate across passes.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= acc_en ? (mem[wr_ptr[ADDR_WIDTH-1:0]] + wr_ext) : wr_ext;
    end
  end

endmodule

// File: rtl/output_mem_ctrl.sv
// Captures skewed column results into per-column banks, then replays them row-aligned on a valid/ready stream.
// First row num_row+1 cycles after start (plus column skew); rows stall in place while out_ready is low.
module output_mem_ctrl
  import neurex_pkg::*;
#(
  parameter int SYS_COL    = NX_SYS_COL,
  parameter int DATA_WIDTH = NX_DATA_WIDTH,
  parameter int ACC_WIDTH  = NX_ACC_WIDTH,
  parameter int ACCUM_ROW  = NX_ACCUM_ROW,
  parameter int ADDR_WIDTH = $clog2(ACCUM_ROW)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start,
  input  logic [31:0]                  num_row,
  input  logic                         acc_en,
  input  logic                         drain_en,
  input  logic [SYS_COL-1:0]           col_valid,
  input  logic signed [DATA_WIDTH-1:0] col_data [SYS_COL],
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [ACC_WIDTH-1:0]  out_data [SYS_COL],
  output logic                         out_last,
  output logic                         busy,
  output logic                         fill_done,
  output logic                         drain_done,
  output logic                         err
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0]         CNT_ONE = PW'(1);
  localparam logic [PW-1:0]         CNT_TWO = PW'(2);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  ctrl_state_e           state;
  logic [PW-1:0]         num_row_q;
  logic                  acc_en_q;
  logic                  drain_en_q;
  logic [ADDR_WIDTH-1:0] rd_ptr;

  logic [SYS_COL-1:0] full;
  logic [SYS_COL-1:0] last_slot;
  logic [SYS_COL-1:0] wr_en;
  logic               start_ok;
  logic               bad_start;
  logic               fill_complete;
  logic               col_err;

  assign start_ok  = (state == IDLE) && start && (num_row != 32'd0) && (num_row <= 32'(ACCUM_ROW));
  assign bad_start = (state == IDLE) && start && !start_ok;
  assign wr_en     = (state == FILL) ? (col_valid & ~full) : '0;
  // Complete when every column is either already full or fills its last slot this cycle.
  assign fill_complete = (state == FILL) && (&(full | (wr_en & last_slot)));
  assign col_err   = (state == FILL) ? |(col_valid & full) : |col_valid;
  assign busy      = (state != IDLE);

  for (genvar j = 0; j < SYS_COL; j++) begin : g_bank
    acc_bank #(
      .DATA_WIDTH(DATA_WIDTH),
      .ACC_WIDTH (ACC_WIDTH),
      .ACCUM_ROW (ACCUM_ROW),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_bank (
      .clk      (clk),
      .rstn     (rstn),
      .clr      (start_ok),
      .wr_en    (wr_en[j]),
      .acc_en   (acc_en_q),
      .num_row  (num_row_q),
      .wr_data  (col_data[j]),
      .rd_addr  (rd_ptr),
      .rd_data  (out_data[j]),
      .full     (full[j]),
      .last_slot(last_slot[j])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      num_row_q  <= '0;
      acc_en_q   <= 1'b0;
      drain_en_q <= 1'b0;
      rd_ptr     <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      fill_done  <= 1'b0;
      drain_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      fill_done  <= 1'b0;
      drain_done <= 1'b0;
      err        <= (start_ok ? 1'b0 : err) | col_err | bad_start;

      case (state)
        IDLE: begin
          if (start_ok) begin
            num_row_q  <= num_row[PW-1:0];
            acc_en_q   <= acc_en;
            drain_en_q <= drain_en;
            state      <= FILL;
          end
        end

        FILL: begin
          if (fill_complete) begin
            fill_done <= 1'b1;
            if (drain_en_q) begin
              state     <= DRAIN;
              rd_ptr    <= '0;
              out_valid <= 1'b1;
              out_last  <= (num_row_q == CNT_ONE);
            end else begin
              state <= IDLE;
            end
          end
        end

        DRAIN: begin
          if (out_ready) begin
            if (out_last) begin
              state      <= IDLE;
              out_valid  <= 1'b0;
              out_last   <= 1'b0;
              drain_done <= 1'b1;
            end else begin
              rd_ptr   <= rd_ptr + PTR_ONE;
              out_last <= (({1'b0, rd_ptr} + CNT_TWO) == num_row_q);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_mem_ctrl.sv
// Randomized directed bench for output_mem_ctrl against a row/column array model of the banks.
module tb_output_mem_ctrl;

  localparam int SC = 16;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int AR = 128;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 start;
  logic [31:0]          num_row;
  logic                 acc_en;
  logic                 drain_en;
  logic [SC-1:0]        col_valid;
  logic signed [DW-1:0] col_data [SC];
  logic                 out_valid;
  logic                 out_ready;
  logic signed [AW-1:0] out_data [SC];
  logic                 out_last;
  logic                 busy;
  logic                 fill_done;
  logic                 drain_done;
  logic                 err;

  int total = 0;
  int bad   = 0;
  int ref_bank [SC][AR];
  bit exp_err;

  always #5 clk = ~clk;

  output_mem_ctrl #(
    .SYS_COL   (SC),
    .DATA_WIDTH(DW),
    .ACC_WIDTH (AW),
    .ACCUM_ROW (AR)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .num_row   (num_row),
    .acc_en    (acc_en),
    .drain_en  (drain_en),
    .col_valid (col_valid),
    .col_data  (col_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .fill_done (fill_done),
    .drain_done(drain_done),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_last"}, 32'(out_last), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_fill_done"}, 32'(fill_done), 32'd0);
    chk({tag, "_drain_done"}, 32'(drain_done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  // dmode: 0 random, 1 row index, 2 10*col+row, 3 constant cval
  // skew:  0 aligned, 1 diagonal (col j delayed j), 2 random delays with gaps
  // rmode: 0 always ready, 1 pattern 1,0,0,1, 2 random
  task automatic run_pass(input int n, input bit acc, input bit drain, input int dmode,
                          input int cval, input int skew, input int rmode, input bit inj);
    int dat [SC][AR];
    int ptr [SC];
    int dly [SC];
    int cyc;
    int r;
    int k;
    bit done;
    bit injected;
    bit rdy;
    logic [SC-1:0] cv;

    for (int j = 0; j < SC; j++) begin
      ptr[j] = 0;
      case (skew)
        1:       dly[j] = j;
        2:       dly[j] = $urandom_range(0, 6);
        default: dly[j] = 0;
      endcase
      for (int i = 0; i < n; i++) begin
        case (dmode)
          1:       dat[j][i] = i;
          2:       dat[j][i] = 10 * j + i;
          3:       dat[j][i] = cval;
          default: dat[j][i] = int'(shortint'($urandom));
        endcase
        ref_bank[j][i] = acc ? (ref_bank[j][i] + dat[j][i]) : dat[j][i];
      end
    end

    @(negedge clk);
    start    = 1'b1;
    num_row  = n;
    acc_en   = acc;
    drain_en = drain;
    @(negedge clk);
    start    = 1'b0;
    num_row  = $urandom;
    acc_en   = 1'($urandom_range(0, 1));
    drain_en = 1'($urandom_range(0, 1));
    exp_err  = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_err_clear", 32'(err), 32'd0);

    cyc = 0;
    done = 1'b0;
    injected = 1'b0;
    while (!done) begin
      cv = '0;
      for (int j = 0; j < SC; j++) begin
        col_data[j] = 16'($urandom);
        if (ptr[j] < n && cyc >= dly[j] && (skew != 2 || $urandom_range(0, 3) != 0)) begin
          cv[j] = 1'b1;
          col_data[j] = 16'(dat[j][ptr[j]]);
          ptr[j]++;
        end
      end
      done = 1'b1;
      for (int j = 0; j < SC; j++) if (ptr[j] != n) done = 1'b0;
      if (inj && !done && !injected && ptr[3] == n && !cv[3]) begin
        cv[3] = 1'b1;
        injected = 1'b1;
        exp_err = 1'b1;
      end
      if (skew == 1 && cyc == 1) begin
        start = 1'b1;
        num_row = 32'd0;
      end
      col_valid = cv;
      @(negedge clk);
      start = 1'b0;
      col_valid = '0;
      cyc++;
      if (!done) begin
        chk("fill_out_valid", 32'(out_valid), 32'd0);
        chk("fill_busy", 32'(busy), 32'd1);
        chk("fill_done_early", 32'(fill_done), 32'd0);
      end
    end

    if (skew == 0) chk("fill_latency", 32'(cyc), 32'(n));
    chk("fill_done", 32'(fill_done), 32'd1);
    chk("fill_err", 32'(err), 32'(exp_err));
    chk("post_fill_busy", 32'(busy), 32'(drain));
    chk("post_fill_out_valid", 32'(out_valid), 32'(drain));

    if (drain) begin
      r = 0;
      k = 0;
      while (r < n && k < 8 * n + 50) begin
        case (rmode)
          1:       rdy = (k % 4 == 0) || (k % 4 == 3);
          2:       rdy = 1'($urandom_range(0, 1));
          default: rdy = 1'b1;
        endcase
        out_ready = rdy;
        chk("drain_out_valid", 32'(out_valid), 32'd1);
        chk($sformatf("drain_last_r%0d", r), 32'(out_last), 32'(r == n - 1));
        for (int j = 0; j < SC; j++)
          chk($sformatf("drain_data_r%0d_c%0d", r, j), out_data[j], ref_bank[j][r]);
        if (out_valid && rdy) r++;
        @(negedge clk);
        k++;
        if (k == 1) chk("fill_done_pulse", 32'(fill_done), 32'd0);
      end
      out_ready = 1'b0;
      chk("drain_rows", 32'(r), 32'(n));
      chk("drain_done", 32'(drain_done), 32'd1);
      chk("drain_end_busy", 32'(busy), 32'd0);
      chk("drain_end_out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("drain_done_pulse", 32'(drain_done), 32'd0);
    end else begin
      @(negedge clk);
      chk("nodrain_fill_done_pulse", 32'(fill_done), 32'd0);
      chk("nodrain_out_valid", 32'(out_valid), 32'd0);
      chk("nodrain_drain_done", 32'(drain_done), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rstn      = 1'b0;
    start     = 1'b0;
    num_row   = 32'd0;
    acc_en    = 1'b0;
    drain_en  = 1'b0;
    col_valid = '0;
    out_ready = 1'b0;
    exp_err   = 1'b0;
    for (int j = 0; j < SC; j++) col_data[j] = '0;

    @(negedge clk);
    chk_idle_outputs("reset");
    @(negedge clk);
    rstn = 1'b1;

    run_pass(8, 1'b0, 1'b1, 1, 0, 0, 0, 1'b0);
    run_pass(8, 1'b0, 1'b1, 2, 0, 1, 0, 1'b0);
    run_pass(8, 1'b0, 1'b0, 3, 3, 0, 0, 1'b0);
    run_pass(8, 1'b1, 1'b1, 3, -5, 0, 0, 1'b0);
    run_pass(12, 1'b0, 1'b1, 0, 0, 0, 1, 1'b0);
    run_pass(128, 1'b0, 1'b1, 0, 0, 2, 2, 1'b0);
    run_pass(1, 1'b1, 1'b1, 0, 0, 0, 0, 1'b0);
    for (int t = 0; t < 3; t++) begin
      n = $urandom_range(1, AR);
      run_pass(n, 1'($urandom_range(0, 1)), 1'b1, 0, 0, 2, 2, 1'b0);
    end

    @(negedge clk);
    start = 1'b1;
    num_row = 32'd0;
    @(negedge clk);
    start = 1'b0;
    chk("zero_rows_err", 32'(err), 32'd1);
    chk("zero_rows_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("zero_rows_still_idle", 32'(busy), 32'd0);

    run_pass(5, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0);

    @(negedge clk);
    start = 1'b1;
    num_row = 32'd129;
    @(negedge clk);
    start = 1'b0;
    chk("oversize_err", 32'(err), 32'd1);
    chk("oversize_busy", 32'(busy), 32'd0);

    run_pass(8, 1'b1, 1'b1, 0, 0, 1, 1, 1'b1);
    run_pass(4, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);

    @(negedge clk);
    col_valid = SC'(1) << 7;
    @(negedge clk);
    col_valid = '0;
    chk("idle_col_valid_err", 32'(err), 32'd1);

    @(negedge clk);
    start = 1'b1;
    num_row = 32'd8;
    acc_en = 1'b0;
    drain_en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      col_valid = '1;
      for (int j = 0; j < SC; j++) col_data[j] = 16'($urandom);
      @(negedge clk);
    end
    col_valid = '0;
    chk("pre_abort_busy", 32'(busy), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk_idle_outputs("abort");
    @(negedge clk);
    rstn = 1'b1;
    exp_err = 1'b0;

    run_pass(8, 1'b0, 1'b1, 0, 0, 2, 2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/output_mem_ctrl.md
Name: output_mem_ctrl

Overview:
Drain-side counterpart of the input memory path. Captures the skewed per-column results leaving the bottom of the systolic array into per-column accumulator banks, optionally adding them to the previous pass. It then replays the banks row-aligned, with all columns of row i together, to the downstream consumer over a valid/ready stream. It sits between the systolic array outputs and the writeback/DMA logic.

Parameters:
SYS_COL, 16, number of array columns (= number of banks)
DATA_WIDTH, 16, signed width of a column result from the array
ACC_WIDTH, 32, signed accumulator/bank word width
ACCUM_ROW, 128, depth of each bank (max rows per tile)
ADDR_WIDTH, $clog2(ACCUM_ROW), derived; bank pointer width

Ports:
clk  in  1  clock, all logic on rising edge
rstn  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a pass (accepted only in IDLE)
num_row  in  32  rows this pass; sampled on accepted start
acc_en  in  1  sampled on start; 1 = add into bank, 0 = overwrite
drain_en  in  1  sampled on start; 1 = stream out after fill
col_valid  in  SYS_COL  per-column result strobe, arbitrary skew between columns
col_data  in  DATA_WIDTH x [0:SYS_COL-1]  signed column results
out_valid  out  1  row available
out_ready  in  1  consumer accepts row
out_data  out  ACC_WIDTH x [0:SYS_COL-1]  row rd_ptr of every bank
out_last  out  1  marks row num_row-1
busy  out  1  state != IDLE
fill_done  out  1  one-cycle pulse, all columns wrote num_row entries
drain_done  out  1  one-cycle pulse, final row handshaken
err  out  1  sticky protocol-error flag

Behaviour:
- States: IDLE, FILL, DRAIN. Reset: state=IDLE; all pointers 0; out_valid, out_last, busy, fill_done, drain_done, err = 0. Bank contents are not reset and are undefined after reset.
- Asynchronous reset mid-pass aborts immediately. The next pass must use acc_en=0 for defined results.
- IDLE, start=1:
  - num_row in 1..ACCUM_ROW: latch num_row, acc_en and drain_en; clear all wr_ptr[j] and err; go to FILL.
  - Otherwise: stay IDLE and set err.
- start outside IDLE is ignored, with no err.
- FILL, col_valid[j]=1 and wr_ptr[j]<num_row:
  - bank[j][wr_ptr[j]] <= acc_en ? bank + sext(col_data[j]) : sext(col_data[j]).
  - wr_ptr[j]++.
  - Addition wraps modulo 2^ACC_WIDTH.
- Columns are independent. Any mix of col_valid bits may be high in the same cycle.
- col_valid[j] with wr_ptr[j]==num_row sets err; the write is dropped. col_valid in IDLE or DRAIN is ignored and sets err.
- Fill complete: the cycle in which the last outstanding column write makes every wr_ptr == num_row.
  - The next edge goes to DRAIN if drain_en, else IDLE.
  - fill_done is high during the first cycle of the new state.
- Banks persist across passes, so acc_en=1 passes accumulate K-tiles.
- DRAIN:
  - rd_ptr=0 on entry; out_valid=1 every DRAIN cycle.
  - out_data[j] = bank[j][rd_ptr] (registered-array read, no extra latency).
  - out_last = (rd_ptr == num_row-1).
- out_valid && out_ready advances rd_ptr. out_data and out_last are held stable while out_ready=0.
- Handshake with out_last goes to IDLE. drain_done is high during the first IDLE cycle. Back-to-back rows are allowed at 1 row/cycle.
- Bank read and write never coincide, since FILL and DRAIN are exclusive. No bypass is needed.
- Latency: minimum start-to-first-out_valid = num_row + 1 cycles with all columns valid every cycle. Skew extends this by the largest column delay.

Decomposition:
- Shared package neurex_pkg holds:
  - typedef enum for the controller state (IDLE/FILL/DRAIN);
  - signed data_t (DATA_WIDTH) and acc_t (ACC_WIDTH) typedefs;
  - ACCUM_ROW default constant.
- One sub-module, acc_bank: a single column bank (ACCUM_ROW x ACC_WIDTH) with write pointer, overwrite/accumulate write and combinational read port. It is instantiated SYS_COL times under a generate loop. The top level holds the FSM, the completion AND-reduce, rd_ptr and err.

Test Plan:
- Reset, then start num_row=8, acc_en=0, drain_en=1, all columns valid for 8 cycles with col_data[j]=i (row i), out_ready=1 -> rows 0..7 out, every column = i; out_last on row 7; fill_done then drain_done, each one cycle.
- Skewed fill: column j valid in cycles j..j+7 (diagonal), data = 10*j+i -> fill_done only after column 15 finishes; row i column j = 10*j+i.
- Accumulate: pass 1 acc_en=0 drain_en=0 with data 3, then pass 2 acc_en=1 drain_en=1 with data -5 -> every word = -2 (0xFFFFFFFE); pass 1 produces no out_valid.
- Backpressure: toggle out_ready 1,0,0,1 during drain -> out_data and out_last stable while stalled; no row skipped or duplicated; exactly num_row handshakes.
- Errors: start num_row=0 -> err=1, stays IDLE. start num_row=129 -> err=1. Extra col_valid[3] after 8 writes -> err=1 and the bank is unchanged. A legal start clears err.
- Reset asserted mid-FILL at wr_ptr=4 -> outputs return to reset values immediately. A fresh acc_en=0 pass then produces correct data.
